// File: rtl/mux_nt1_scan_if.sv
// Bundled select, data and status signals for mux_nt1_scan.
// ch_oh exists only when MUX_NT1_ONEHOT_EN is defined.
interface mux_nt1_scan_if #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2
);
   logic [N*W-1:0]   din;
   logic [SEL_W-1:0] sel;
   logic             sel_we;
   logic             auto;
   logic             hold;
   logic [W-1:0]     dout;
   logic [SEL_W-1:0] ch;
   logic             dout_vld;
   logic             tick;
`ifdef MUX_NT1_ONEHOT_EN
   logic [N-1:0]     ch_oh;

   modport master (
      output din, sel, sel_we, auto, hold,
      input  dout, ch, dout_vld, tick, ch_oh
   );

   modport slave (
      input  din, sel, sel_we, auto, hold,
      output dout, ch, dout_vld, tick, ch_oh
   );
`else
   modport master (
      output din, sel, sel_we, auto, hold,
      input  dout, ch, dout_vld, tick
   );

   modport slave (
      input  din, sel, sel_we, auto, hold,
      output dout, ch, dout_vld, tick
   );
`endif
endinterface

// File: rtl/mux_nt1_scan.sv
// N-to-1 registered mux with a channel register loaded manually or advanced round-robin.
// Optional registered one-hot channel decode (ch_oh) under macro MUX_NT1_ONEHOT_EN.
module mux_nt1_scan #(
   parameter int W      = 32,
   parameter int N      = 4,
   parameter int SEL_W  = 2,
   parameter int PERIOD = 4
) (
   input  logic          clk,
   input  logic          rst,
   mux_nt1_scan_if.slave bus
);
   localparam int               DIV_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N - 1);
   localparam logic [SEL_W-1:0] CH_ZERO  = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0] CH_ONE   = SEL_W'(1);

   logic [SEL_W-1:0] ch_r;
   logic [SEL_W-1:0] ch_nxt_s;
   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] div_nxt_s;
   logic [W-1:0]     dout_r;
   logic [W-1:0]     dout_nxt_s;
   logic             chg_r;
   logic             chg_nxt_s;
   logic             vld_r;
   logic             tick_r;
   logic             tick_nxt_s;

   // Channel and divider next state; a manual load always wins over an auto advance
   always_comb begin
      ch_nxt_s   = ch_r;
      div_nxt_s  = div_r;
      chg_nxt_s  = 1'b0;
      tick_nxt_s = 1'b0;
      if (bus.sel_we) begin
         div_nxt_s = DIV_ZERO;
         if (bus.sel <= CH_LAST) begin
            ch_nxt_s  = bus.sel;
            chg_nxt_s = 1'b1;
         end else begin
            ch_nxt_s = ch_r;
         end
      end else if (bus.auto && !bus.hold) begin
         if (div_r == DIV_LAST) begin
            div_nxt_s  = DIV_ZERO;
            ch_nxt_s   = (ch_r == CH_LAST) ? CH_ZERO : (ch_r + CH_ONE);
            chg_nxt_s  = 1'b1;
            tick_nxt_s = 1'b1;
         end else begin
            div_nxt_s = div_r + DIV_ONE;
         end
      end else if (bus.auto) begin
         div_nxt_s = div_r;
      end else begin
         div_nxt_s = DIV_ZERO;
      end
   end

   // Data select from the current (pre-update) channel register
   always_comb begin
      dout_nxt_s = {W{1'b0}};
      for (int k = 0; k < N; k++) begin
         if (ch_r == SEL_W'(k)) begin
            dout_nxt_s = bus.din[k*W +: W];
         end else begin
            dout_nxt_s = dout_nxt_s;
         end
      end
   end

   // State and output registers; chg_r resets high so channel 0 gets its valid pulse after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_r   <= CH_ZERO;
         div_r  <= DIV_ZERO;
         chg_r  <= 1'b1;
         vld_r  <= 1'b0;
         tick_r <= 1'b0;
         dout_r <= {W{1'b0}};
      end else begin
         ch_r   <= ch_nxt_s;
         div_r  <= div_nxt_s;
         chg_r  <= chg_nxt_s;
         vld_r  <= chg_r;
         tick_r <= tick_nxt_s;
         dout_r <= dout_nxt_s;
      end
   end

   assign bus.dout     = dout_r;
   assign bus.ch       = ch_r;
   assign bus.dout_vld = vld_r;
   assign bus.tick     = tick_r;

`ifdef MUX_NT1_ONEHOT_EN
   logic [N-1:0] ch_oh_r;

   function automatic logic [N-1:0] ch_decode(input logic [SEL_W-1:0] c);
      logic [N-1:0] oh;
      oh = {N{1'b0}};
      for (int k = 0; k < N; k++) begin
         if (c == SEL_W'(k)) begin
            oh[k] = 1'b1;
         end else begin
            oh[k] = 1'b0;
         end
      end
      return oh;
   endfunction

   // One-hot decode registered from ch_nxt_s so it changes on the same edge as ch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_oh_r <= {{(N-1){1'b0}}, 1'b1};
      end else begin
         ch_oh_r <= ch_decode(ch_nxt_s);
      end
   end

   assign bus.ch_oh = ch_oh_r;
`endif

endmodule

// File: tb/tb_mux_nt1_scan.sv
// Directed bench: vector table on a 4-channel PERIOD=4 instance, then hand sequences for
// reset/hold/din tracking and a 3-channel PERIOD=1 instance for non-power-of-2 wrap.
module tb_mux_nt1_scan;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   localparam logic [31:0] A = 32'h11111111;
   localparam logic [31:0] B = 32'h22222222;
   localparam logic [31:0] C = 32'h33333333;
   localparam logic [31:0] D = 32'h44444444;

   mux_nt1_scan_if #(.W(32), .N(4), .SEL_W(2)) b4 ();
   mux_nt1_scan_if #(.W(8),  .N(3), .SEL_W(2)) b3 ();

   mux_nt1_scan #(.W(32), .N(4), .SEL_W(2), .PERIOD(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (b4)
   );

   mux_nt1_scan #(.W(8), .N(3), .SEL_W(2), .PERIOD(1)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (b3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  sel;
      logic        au;
      logic        hd;
      logic [1:0]  ch;
      logic [31:0] dout;
      logic        vld;
      logic        tck;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(input logic we, input logic [1:0] sel, input logic au,
                              input logic hd, input logic [1:0] ch, input logic [31:0] dout,
                              input logic vld, input logic tck);
      vec_t r;
      r.we = we; r.sel = sel; r.au = au; r.hd = hd;
      r.ch = ch; r.dout = dout; r.vld = vld; r.tck = tck;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [1:0] ch, input logic [31:0] dout,
                       input logic vld, input logic tck);
      check({tag, " ch"},   {30'd0, b4.ch}, {30'd0, ch});
      check({tag, " dout"}, b4.dout, dout);
      check({tag, " vld"},  {31'd0, b4.dout_vld}, {31'd0, vld});
      check({tag, " tick"}, {31'd0, b4.tick}, {31'd0, tck});
`ifdef MUX_NT1_ONEHOT_EN
      begin
         logic [3:0] oh;
         oh = 4'b0001 << ch;
         check({tag, " ch_oh"}, {28'd0, b4.ch_oh}, {28'd0, oh});
      end
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] d3 [3];
      n_checks = 0;
      n_errors = 0;
      d3[0] = 8'hA1; d3[1] = 8'hB2; d3[2] = 8'hC3;

      b4.din = {D, C, B, A};
      b4.sel = 2'd0; b4.sel_we = 1'b0; b4.auto = 1'b0; b4.hold = 1'b0;
      b3.din = {d3[2], d3[1], d3[0]};
      b3.sel = 2'd0; b3.sel_we = 1'b0; b3.auto = 1'b0; b3.hold = 1'b0;

      // vector table: we, sel, auto, hold -> ch, dout, vld, tick after the edge
      vt.push_back(v(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, A, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, A, 1'b0, 1'b0));
      vt.push_back(v(1'b1, 2'd2, 1'b0, 1'b0, 2'd2, A, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b0, 1'b0, 2'd2, C, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b0, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b1, 2'd2, 1'b0, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b0, 1'b0, 2'd2, C, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd3, C, 1'b0, 1'b1));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd3, D, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd3, D, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd3, D, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, D, 1'b0, 1'b1));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, A, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, A, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, A, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, A, 1'b0, 1'b1));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, B, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, B, 1'b0, 1'b0));
      // load sel=0 on the cycle the divider sits at PERIOD-1: advance dropped
      vt.push_back(v(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, A, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, A, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, A, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, A, 1'b0, 1'b1));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, B, 1'b1, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b1, 2'd1, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b1, 2'd1, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b1, 2'd1, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd1, B, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, B, 1'b0, 1'b1));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b1, 1'b0));
      // auto dropped mid-dwell: channel kept, divider restarts
      vt.push_back(v(1'b0, 2'd0, 1'b0, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd2, C, 1'b0, 1'b0));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd3, C, 1'b0, 1'b1));
      vt.push_back(v(1'b0, 2'd0, 1'b1, 1'b0, 2'd3, D, 1'b1, 1'b0));

      rst = 1'b1;
      step();
      step();
      chk4("reset", 2'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vt[i]) begin
         b4.sel_we = vt[i].we;
         b4.sel    = vt[i].sel;
         b4.auto   = vt[i].au;
         b4.hold   = vt[i].hd;
         step();
         chk4($sformatf("vec%0d", i), vt[i].ch, vt[i].dout, vt[i].vld, vt[i].tck);
      end

      // mid-scan async reset with ch=2 and auto running
      b4.sel_we = 1'b1; b4.sel = 2'd2; b4.auto = 1'b1; b4.hold = 1'b0;
      step();
      b4.sel_we = 1'b0;
      step();
      check("pre-reset ch", {30'd0, b4.ch}, 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk4("async reset", 2'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk4("rel e1", 2'd0, A, 1'b1, 1'b0);
      step();
      chk4("rel e2", 2'd0, A, 1'b0, 1'b0);
      step();
      chk4("rel e3", 2'd0, A, 1'b0, 1'b0);
      step();
      chk4("rel e4", 2'd1, A, 1'b0, 1'b1);
      step();
      step();
      chk4("pre-hold", 2'd1, B, 1'b0, 1'b0);
      b4.hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk4($sformatf("hold%0d", i), 2'd1, B, 1'b0, 1'b0);
      end
      b4.hold = 1'b0;
      step();
      chk4("resume div3", 2'd1, B, 1'b0, 1'b0);
      step();
      chk4("resume adv", 2'd2, B, 1'b0, 1'b1);

      // din changes follow on dout one edge later while ch is stable
      b4.auto = 1'b0; b4.sel_we = 1'b1; b4.sel = 2'd3;
      step();
      b4.sel_we = 1'b0;
      step();
      chk4("din base", 2'd3, D, 1'b1, 1'b0);
      b4.din = {32'hDEADBEEF, C, B, 32'h55555555};
      #1;
      check("din no comb", b4.dout, D);
      step();
      chk4("din new", 2'd3, 32'hDEADBEEF, 1'b0, 1'b0);
      b4.din = {D, C, B, A};

      // N=3, PERIOD=1: advance every edge, wrap 2->0, tick/vld held high
      b3.auto = 1'b1;
      #2;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         check($sformatf("n3 ch e%0d", i), {30'd0, b3.ch}, i % 3);
         check($sformatf("n3 dout e%0d", i), {24'd0, b3.dout}, {24'd0, d3[(i - 1) % 3]});
         check($sformatf("n3 tick e%0d", i), {31'd0, b3.tick}, 32'd1);
         check($sformatf("n3 vld e%0d", i), {31'd0, b3.dout_vld}, 32'd1);
      end
      b3.auto = 1'b0;
      step();
      check("n3 stop ch", {30'd0, b3.ch}, 32'd1);
      check("n3 stop tick", {31'd0, b3.tick}, 32'd0);
      step();
      check("n3 idle vld", {31'd0, b3.dout_vld}, 32'd0);
      b3.sel_we = 1'b1; b3.sel = 2'd3;
      step();
      b3.sel_we = 1'b0;
      check("n3 bad sel ch", {30'd0, b3.ch}, 32'd1);
      step();
      check("n3 bad sel vld", {31'd0, b3.dout_vld}, 32'd0);
      check("n3 bad sel dout", {24'd0, b3.dout}, {24'd0, d3[1]});
      b3.sel_we = 1'b1; b3.sel = 2'd2;
      step();
      b3.sel_we = 1'b0;
      check("n3 sel2 ch", {30'd0, b3.ch}, 32'd2);
      step();
      check("n3 sel2 vld", {31'd0, b3.dout_vld}, 32'd1);
      check("n3 sel2 dout", {24'd0, b3.dout}, {24'd0, d3[2]});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
